wide_port_fifo_mr: RTL and testbench
====================================

Name: wide_port_fifo_mr

Overview:
- Multi-rate FIFO for event capture. Each cycle it accepts a variable number of input words, 0..NUM_INPUTS.
- Each read pops up to NUM_OUTPUTS words, set by parameter.
- Adds over the previous generation: registered output with valid/count, a drain mode for partial tail reads, flush, an almost-full threshold, and overflow/underflow pulses.
- Sits between the event packers and the event packet assembler.

Parameters:
- INPUT_WORD_SIZE, 32: bits per word.
- NUM_INPUTS, 8: maximum words written per cycle.
- NUM_OUTPUTS, 2: words popped per read.
- DEPTH_BITS, 5: FIFO depth is 2**DEPTH_BITS words. Legal only if DEPTH >= NUM_INPUTS and DEPTH >= NUM_OUTPUTS.
- NUM_INPUTS_SIZE, log2(NUM_INPUTS+1): width of increment.
- NUM_OUTPUTS_SIZE, log2(NUM_OUTPUTS+1): width of out_count.
- ALMOST_FULL_THRESH, DEPTH-2*NUM_INPUTS: occupancy at which almost_full asserts.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- d_in  in  INPUT_WORD_SIZE*NUM_INPUTS  input words; word i is at bits [i*W +: W].
- increment  in  NUM_INPUTS_SIZE  number of words (low-order first) to write.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- drain  in  1  allow a partial read when fewer than NUM_OUTPUTS words are stored.
- flush  in  1  synchronous discard of all contents.
- d_out  out  INPUT_WORD_SIZE*NUM_OUTPUTS  registered read data; oldest word is word 0.
- out_valid  out  1  d_out holds data popped in the previous cycle.
- out_count  out  NUM_OUTPUTS_SIZE  number of valid words in d_out.
- empty  out  1  fewer than NUM_OUTPUTS words stored.
- full  out  1  free space < NUM_INPUTS.
- almost_full  out  1  occupancy >= ALMOST_FULL_THRESH.
- num_words_in_fifo  out  DEPTH_BITS+1  current occupancy.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=1):
  - wr_ptr, rd_ptr, num_words_in_fifo and d_out are 0.
  - out_valid, out_count, overflow and underflow are 0.
  - empty=1, full=0, almost_full=0 (ALMOST_FULL_THRESH>0).
  - Storage contents are don't-care.
- Priority: rst > flush > normal operation.
- Flush:
  - Clears pointers and occupancy, and drops any same-cycle write or read.
  - Next cycle: out_valid=0 and out_count=0; d_out holds its value.
  - No overflow or underflow pulse is generated.
- Effective write count: eff_inc = min(increment, NUM_INPUTS).
- Write accept: wr_acc = wr_en & ~full.
  - Words 0..eff_inc-1 are stored at (wr_ptr+i) mod DEPTH.
  - wr_ptr += eff_inc, modulo 2**DEPTH_BITS with natural wrap.
  - wr_en with eff_inc=0 is accepted as a no-op.
- Overflow: pulses the next cycle when wr_en & full & eff_inc!=0.
- Read accept: rd_acc = rd_en & (num >= NUM_OUTPUTS | (drain & num != 0)).
  - pop = min(num, NUM_OUTPUTS).
  - rd_ptr += pop.
- Underflow: pulses the next cycle when rd_en & ~rd_acc.
- Read latency is 1 cycle.
  - Cycle after rd_acc: d_out word k = mem[(rd_ptr+k) mod DEPTH] for k<pop, and 0 for k>=pop.
  - Same cycle: out_count=pop, out_valid=1.
  - Cycle after no rd_acc: out_valid=0 and out_count=0; d_out holds its value.
- Occupancy update: num_next = num + (wr_acc ? eff_inc : 0) - (rd_acc ? pop : 0).
  - All flags are computed from pre-cycle occupancy.
  - Data written in a cycle is not readable until the following cycle, even when the FIFO is empty.
- Simultaneous read and write with wr_ptr/rd_ptr wrap in the same cycle must be correct. Read and write never overlap, because full guarantees NUM_INPUTS free slots.
- Flag definitions (combinational from registered occupancy):
  - full = num > DEPTH-NUM_INPUTS
  - empty = num < NUM_OUTPUTS
  - almost_full = num >= ALMOST_FULL_THRESH
- Storage is a register array. Per-word write enables are decoded from eff_inc and wr_ptr. The read gather is a NUM_OUTPUTS-way mux indexed from rd_ptr.

Test Plan:
- Reset, then idle:
  - Required: empty=1, full=0, num=0.
  - rd_en=1 -> underflow=1 next cycle, out_valid=0.
- Defaults; write inc=3 of 0xA,0xB,0xC, then rd_en:
  - Required after the read: d_out={0xB,0xA}, out_count=2, num=1.
  - Second rd_en without drain -> underflow.
  - With drain -> d_out={0,0xC}, out_count=1, num=0.
- Fill with inc=8 writes:
  - After 3 writes: num=24, full=0 (24 is not > 24), almost_full=1 (24>=16).
  - 4th write accepted: num=32, full=1.
  - 5th write -> overflow pulse, num stays 32.
- Wrap:
  - Write an incrementing pattern 40 times with inc=5 while reading every cycle.
  - Required: output sequence is gap-free and in order, and num never exceeds 32.
- Simultaneous op at num=2: wr inc=4 plus rd -> num=4, popped words are the oldest two.
- Flush at num=10 with same-cycle wr inc=8 -> num=0, empty=1, out_valid=0, no overflow.
- rst asserted while out_valid=1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/wide_port_fifo_mr.sv
// Multi-rate event FIFO: writes 0..NUM_INPUTS words per cycle, pops up to NUM_OUTPUTS
// words per read into a registered output, with drain, flush and occupancy flags.
module wide_port_fifo_mr #(
   parameter int INPUT_WORD_SIZE    = 32,
   parameter int NUM_INPUTS         = 8,
   parameter int NUM_OUTPUTS        = 2,
   parameter int DEPTH_BITS         = 5,
   parameter int NUM_INPUTS_SIZE    = $clog2(NUM_INPUTS + 1),
   parameter int NUM_OUTPUTS_SIZE   = $clog2(NUM_OUTPUTS + 1),
   parameter int ALMOST_FULL_THRESH = (2 ** DEPTH_BITS) - 2 * NUM_INPUTS
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [INPUT_WORD_SIZE*NUM_INPUTS-1:0]   d_in,
   input  logic [NUM_INPUTS_SIZE-1:0]              increment,
   input  logic                                    wr_en,
   input  logic                                    rd_en,
   input  logic                                    drain,
   input  logic                                    flush,
   output logic [INPUT_WORD_SIZE*NUM_OUTPUTS-1:0]  d_out,
   output logic                                    out_valid,
   output logic [NUM_OUTPUTS_SIZE-1:0]             out_count,
   output logic                                    empty,
   output logic                                    full,
   output logic                                    almost_full,
   output logic [DEPTH_BITS:0]                     num_words_in_fifo,
   output logic                                    overflow,
   output logic                                    underflow
);

   localparam int W     = INPUT_WORD_SIZE;
   localparam int DEPTH = 2 ** DEPTH_BITS;
   localparam int OCC_W = DEPTH_BITS + 1;

   localparam logic [OCC_W-1:0]            FULL_LIM = OCC_W'(DEPTH - NUM_INPUTS);
   localparam logic [OCC_W-1:0]            AF_LIM   = OCC_W'(ALMOST_FULL_THRESH);
   localparam logic [OCC_W-1:0]            NOUT_OCC = OCC_W'(NUM_OUTPUTS);
   localparam logic [NUM_INPUTS_SIZE-1:0]  MAX_INC  = NUM_INPUTS_SIZE'(NUM_INPUTS);
   localparam logic [NUM_OUTPUTS_SIZE-1:0] MAX_POP  = NUM_OUTPUTS_SIZE'(NUM_OUTPUTS);

   logic [W-1:0]                  mem_r [DEPTH];
   logic [DEPTH_BITS-1:0]         wr_ptr_r;
   logic [DEPTH_BITS-1:0]         rd_ptr_r;
   logic [OCC_W-1:0]              num_r;
   logic [W*NUM_OUTPUTS-1:0]      d_out_r;
   logic                          out_valid_r;
   logic [NUM_OUTPUTS_SIZE-1:0]   out_count_r;
   logic                          overflow_r;
   logic                          underflow_r;

   logic [NUM_INPUTS_SIZE-1:0]    eff_inc_s;
   logic [NUM_OUTPUTS_SIZE-1:0]   pop_s;
   logic                          full_s;
   logic                          wr_acc_s;
   logic                          rd_acc_s;
   logic [OCC_W-1:0]              num_next_s;
   logic [DEPTH-1:0]              we_s;
   logic [W-1:0]                  wdata_s [DEPTH];
   logic [W*NUM_OUTPUTS-1:0]      rdata_s;

   assign full_s   = (num_r > FULL_LIM);
   assign wr_acc_s = wr_en & ~full_s;
   assign rd_acc_s = rd_en & ((num_r >= NOUT_OCC) | (drain & (num_r != {OCC_W{1'b0}})));

   // Saturate the write count and size the pop from pre-cycle occupancy
   always_comb begin
      eff_inc_s = increment;
      pop_s     = MAX_POP;
      if (increment > MAX_INC) begin
         eff_inc_s = MAX_INC;
      end else begin
         eff_inc_s = increment;
      end
      if (num_r >= NOUT_OCC) begin
         pop_s = MAX_POP;
      end else begin
         pop_s = NUM_OUTPUTS_SIZE'(num_r);
      end
   end

   assign num_next_s = num_r
                     + (wr_acc_s ? OCC_W'(eff_inc_s) : {OCC_W{1'b0}})
                     - (rd_acc_s ? OCC_W'(pop_s)     : {OCC_W{1'b0}});

   // Per-slot write enable and data select, decoded from wr_ptr and eff_inc
   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         we_s[j]    = 1'b0;
         wdata_s[j] = {W{1'b0}};
         for (int i = 0; i < NUM_INPUTS; i++) begin
            we_s[j]    = we_s[j] | (wr_acc_s & ~flush
                         & (NUM_INPUTS_SIZE'(i) < eff_inc_s)
                         & ((wr_ptr_r + DEPTH_BITS'(i)) == DEPTH_BITS'(j)));
            wdata_s[j] = ((wr_ptr_r + DEPTH_BITS'(i)) == DEPTH_BITS'(j)) ? d_in[i*W +: W] : wdata_s[j];
         end
      end
   end

   // Read gather: oldest word lands in lane 0, lanes beyond the pop read as zero
   always_comb begin
      rdata_s = {(W*NUM_OUTPUTS){1'b0}};
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
         if (NUM_OUTPUTS_SIZE'(k) < pop_s) begin
            rdata_s[k*W +: W] = mem_r[rd_ptr_r + DEPTH_BITS'(k)];
         end else begin
            rdata_s[k*W +: W] = {W{1'b0}};
         end
      end
   end

   // Storage array, no reset needed on contents
   always_ff @(posedge clk) begin
      for (int j = 0; j < DEPTH; j++) begin
         if (we_s[j]) begin
            mem_r[j] <= wdata_s[j];
         end
      end
   end

   // Pointers, occupancy and registered read port
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= {DEPTH_BITS{1'b0}};
         rd_ptr_r    <= {DEPTH_BITS{1'b0}};
         num_r       <= {OCC_W{1'b0}};
         d_out_r     <= {(W*NUM_OUTPUTS){1'b0}};
         out_valid_r <= 1'b0;
         out_count_r <= {NUM_OUTPUTS_SIZE{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (flush) begin
         wr_ptr_r    <= {DEPTH_BITS{1'b0}};
         rd_ptr_r    <= {DEPTH_BITS{1'b0}};
         num_r       <= {OCC_W{1'b0}};
         out_valid_r <= 1'b0;
         out_count_r <= {NUM_OUTPUTS_SIZE{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + DEPTH_BITS'(eff_inc_s);
         end
         if (rd_acc_s) begin
            rd_ptr_r <= rd_ptr_r + DEPTH_BITS'(pop_s);
            d_out_r  <= rdata_s;
         end
         num_r       <= num_next_s;
         out_valid_r <= rd_acc_s;
         out_count_r <= rd_acc_s ? pop_s : {NUM_OUTPUTS_SIZE{1'b0}};
         overflow_r  <= wr_en & full_s & (eff_inc_s != {NUM_INPUTS_SIZE{1'b0}});
         underflow_r <= rd_en & ~rd_acc_s;
      end
   end

   assign d_out             = d_out_r;
   assign out_valid         = out_valid_r;
   assign out_count         = out_count_r;
   assign num_words_in_fifo = num_r;
   assign overflow          = overflow_r;
   assign underflow         = underflow_r;
   assign full              = full_s;
   assign empty             = (num_r < NOUT_OCC);
   assign almost_full       = (num_r >= AF_LIM);

endmodule

// File: tb/tb_wide_port_fifo_mr.sv
// Directed self-checking bench for wide_port_fifo_mr at default parameters
// (8 inputs, 2 outputs, depth 32, almost-full threshold 16).
module tb_wide_port_fifo_mr;

   localparam int W  = 32;
   localparam int NI = 8;

   logic          clk = 1'b0;
   logic          rst, wr_en, rd_en, drain, flush;
   logic [255:0]  d_in;
   logic [3:0]    increment;
   logic [63:0]   d_out;
   logic          out_valid, empty, full, almost_full, overflow, underflow;
   logic [1:0]    out_count;
   logic [5:0]    num;

   int total = 0;
   int bad   = 0;

   wide_port_fifo_mr dut (
      .clk(clk), .rst(rst), .d_in(d_in), .increment(increment), .wr_en(wr_en),
      .rd_en(rd_en), .drain(drain), .flush(flush), .d_out(d_out), .out_valid(out_valid),
      .out_count(out_count), .empty(empty), .full(full), .almost_full(almost_full),
      .num_words_in_fifo(num), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; drain = 1'b0; flush = 1'b0;
      increment = 4'd0; d_in = '0;
   endtask

   // Drive all eight lanes with base+i; only the first n are meant to be stored
   task automatic load(input int n, input logic [31:0] base);
      for (int i = 0; i < NI; i++) d_in[i*W +: W] = base + 32'(i);
      increment = 4'(n);
      wr_en = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
      total++; if (num !== 6'd0) begin bad++; $display("FAIL reset_num got=%0d exp=0", num); end
      total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", almost_full); end
      total++; if (d_out !== 64'd0) begin bad++; $display("FAIL reset_dout got=%h exp=0", d_out); end
      rd_en = 1'b1;
      step();
      idle();
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL idle_underflow got=%b exp=1", underflow); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
      step();
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_pulse got=%b exp=0", underflow); end
   endtask

   task automatic test_basic();
      do_reset();
      load(3, 32'hA);
      step();
      idle();
      total++; if (num !== 6'd3) begin bad++; $display("FAIL basic_num3 got=%0d exp=3", num); end
      rd_en = 1'b1;
      step();
      total++; if (d_out !== {32'hB, 32'hA}) begin bad++; $display("FAIL basic_rd1 got=%h exp=%h", d_out, {32'hB, 32'hA}); end
      total++; if (out_count !== 2'd2) begin bad++; $display("FAIL basic_cnt1 got=%0d exp=2", out_count); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_val1 got=%b exp=1", out_valid); end
      total++; if (num !== 6'd1) begin bad++; $display("FAIL basic_num1 got=%0d exp=1", num); end
      step();
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL basic_nodrain_uf got=%b exp=1", underflow); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_nodrain_val got=%b exp=0", out_valid); end
      total++; if (d_out !== {32'hB, 32'hA}) begin bad++; $display("FAIL basic_hold got=%h exp=%h", d_out, {32'hB, 32'hA}); end
      drain = 1'b1;
      step();
      idle();
      total++; if (d_out !== {32'h0, 32'hC}) begin bad++; $display("FAIL drain_data got=%h exp=%h", d_out, {32'h0, 32'hC}); end
      total++; if (out_count !== 2'd1) begin bad++; $display("FAIL drain_cnt got=%0d exp=1", out_count); end
      total++; if (num !== 6'd0) begin bad++; $display("FAIL drain_num got=%0d exp=0", num); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int n = 0; n < 3; n++) begin
         load(8, 32'h200 + 32'(n * 8));
         step();
      end
      total++; if (num !== 6'd24) begin bad++; $display("FAIL fill_num24 got=%0d exp=24", num); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full24 got=%b exp=0", full); end
      total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL fill_af24 got=%b exp=1", almost_full); end
      load(8, 32'h218);
      step();
      total++; if (num !== 6'd32) begin bad++; $display("FAIL fill_num32 got=%0d exp=32", num); end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full32 got=%b exp=1", full); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_ovf got=%b exp=0", overflow); end
      load(8, 32'hDEAD0000);
      step();
      idle();
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
      total++; if (num !== 6'd32) begin bad++; $display("FAIL fill_ovf_num got=%0d exp=32", num); end
      step();
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b exp=0", overflow); end
      rd_en = 1'b1;
      for (int r = 0; r < 16; r++) begin
         step();
         total++;
         if (d_out !== {32'h200 + 32'(2*r+1), 32'h200 + 32'(2*r)}) begin
            bad++; $display("FAIL fill_rd%0d got=%h exp=%h", r, d_out, {32'h200 + 32'(2*r+1), 32'h200 + 32'(2*r)});
         end
      end
      idle();
      step();
      total++; if (num !== 6'd0) begin bad++; $display("FAIL fill_drained got=%0d exp=0", num); end
   endtask

   task automatic test_wrap();
      int num_m, wcnt;
      logic [31:0] q[$];
      logic [31:0] e0, e1;
      logic wacc, racc;
      do_reset();
      num_m = 0; wcnt = 0; e0 = 32'd0; e1 = 32'd0;
      for (int c = 0; c < 40; c++) begin
         load(5, 32'(wcnt));
         rd_en = 1'b1;
         wacc = (num_m <= 24);
         racc = (num_m >= 2);
         if (racc) begin e0 = q.pop_front(); e1 = q.pop_front(); end
         if (wacc) begin
            for (int i = 0; i < 5; i++) q.push_back(32'(wcnt + i));
            wcnt += 5;
         end
         num_m = num_m + (wacc ? 5 : 0) - (racc ? 2 : 0);
         step();
         total++; if (out_valid !== racc) begin bad++; $display("FAIL wrap_val c=%0d got=%b exp=%b", c, out_valid, racc); end
         if (racc) begin
            total++; if (d_out !== {e1, e0}) begin bad++; $display("FAIL wrap_data c=%0d got=%h exp=%h", c, d_out, {e1, e0}); end
         end
         total++; if (num !== 6'(num_m)) begin bad++; $display("FAIL wrap_num c=%0d got=%0d exp=%0d", c, num, num_m); end
         total++; if (num > 6'd32) begin bad++; $display("FAIL wrap_bound c=%0d got=%0d exp<=32", c, num); end
         total++; if (overflow !== ~wacc) begin bad++; $display("FAIL wrap_ovf c=%0d got=%b exp=%b", c, overflow, ~wacc); end
      end
      idle();
   endtask

   task automatic test_simul();
      do_reset();
      load(2, 32'h10);
      step();
      total++; if (num !== 6'd2) begin bad++; $display("FAIL simul_pre got=%0d exp=2", num); end
      load(4, 32'h20);
      rd_en = 1'b1;
      step();
      total++; if (num !== 6'd4) begin bad++; $display("FAIL simul_num got=%0d exp=4", num); end
      total++; if (d_out !== {32'h11, 32'h10}) begin bad++; $display("FAIL simul_data got=%h exp=%h", d_out, {32'h11, 32'h10}); end
      idle();
      rd_en = 1'b1;
      step();
      idle();
      total++; if (d_out !== {32'h21, 32'h20}) begin bad++; $display("FAIL simul_next got=%h exp=%h", d_out, {32'h21, 32'h20}); end
   endtask

   task automatic test_flush();
      do_reset();
      load(8, 32'h100);
      step();
      load(4, 32'h108);
      step();
      idle();
      rd_en = 1'b1;
      step();
      total++; if (num !== 6'd10) begin bad++; $display("FAIL flush_pre got=%0d exp=10", num); end
      flush = 1'b1;
      load(8, 32'h300);
      step();
      idle();
      total++; if (num !== 6'd0) begin bad++; $display("FAIL flush_num got=%0d exp=0", num); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b exp=1", empty); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_val got=%b exp=0", out_valid); end
      total++; if (out_count !== 2'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", out_count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
      total++; if (underflow !== 1'b0) begin bad++; $display("FAIL flush_uf got=%b exp=0", underflow); end
      total++; if (d_out !== {32'h101, 32'h100}) begin bad++; $display("FAIL flush_hold got=%h exp=%h", d_out, {32'h101, 32'h100}); end
      rd_en = 1'b1; drain = 1'b1;
      step();
      idle();
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL flush_dropped_wr got=%b exp=1", underflow); end
   endtask

   task automatic test_rst_mid();
      do_reset();
      load(2, 32'h40);
      step();
      idle();
      rd_en = 1'b1;
      step();
      idle();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", out_valid); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_val got=%b exp=0", out_valid); end
      total++; if (d_out !== 64'd0) begin bad++; $display("FAIL rstmid_dout got=%h exp=0", d_out); end
      total++; if (out_count !== 2'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", out_count); end
      total++; if (num !== 6'd0) begin bad++; $display("FAIL rstmid_num got=%0d exp=0", num); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_basic();
      test_fill();
      test_wrap();
      test_simul();
      test_flush();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
